// File: rtl/framed_shift_register.sv
// framed_shift_register: width-configurable serial/parallel shifter with bit-counter word framing
module framed_shift_register #(
    parameter int width = 8,
    parameter int counterWidth = 4,
    parameter int lsbFirst = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    peripheralClkEdge,
    input  logic                    parallelLoad,
    input  logic [width-1:0]        parallelDataIn,
    input  logic                    serialDataIn,
    output logic [width-1:0]        parallelDataOut,
    output logic                    serialDataOut,
    output logic [width-1:0]        wordOut,
    output logic                    wordDone,
    output logic [counterWidth-1:0] bitCount
);
    logic [width-1:0] mem;
    logic [width-1:0] memShifted;
    logic             lastBit;
    always_comb begin
        memShifted = (lsbFirst != 0) ? {serialDataIn, mem[width-1:1]} : {mem[width-2:0], serialDataIn};
        lastBit = bitCount == counterWidth'(width - 1);
        parallelDataOut = mem;
        serialDataOut = (lsbFirst != 0) ? mem[0] : mem[width-1];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            mem <= '0;
            wordOut <= '0;
            bitCount <= '0;
            wordDone <= 1'b0;
        end else if (parallelLoad) begin
            mem <= parallelDataIn;
            bitCount <= '0;
            wordDone <= 1'b0;
        end else if (peripheralClkEdge) begin
            mem <= memShifted;
            bitCount <= lastBit ? '0 : bitCount + counterWidth'(1);
            wordDone <= lastBit;
            if (lastBit) wordOut <= memShifted;
        end else begin
            wordDone <= 1'b0;
        end
    end
endmodule

// File: doc/framed_shift_register.md
Name: framed_shift_register

Overview:
Parametrised serial/parallel shift register for peripheral links (SPI-style). Successor to the basic 8-bit shifter: configurable word width and bit order, synchronous reset, and an internal bit counter. The counter frames serial words and reports word completion with a captured copy of each finished word. Sits between a peripheral clock-edge detector (supplies one-cycle strobes in the clk domain) and the parallel-side register interface.

Parameters:
width, 8, word width in bits (>= 2)
counterWidth, 4, bit-counter width; must satisfy 2^counterWidth >= width
lsbFirst, 0, 0 = MSB shifted out/in first; 1 = LSB first

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
peripheralClkEdge  input  1  shift strobe, sampled on clk; each clk cycle it is high = one shift
parallelLoad  input  1  load parallelDataIn into shift register
parallelDataIn  input  width  word to load
serialDataIn  input  1  serial input bit, sampled with the strobe
parallelDataOut  output  width  live shift register contents
serialDataOut  output  1  current outgoing bit: mem[width-1] if lsbFirst=0, else mem[0]
wordOut  output  width  last completed serial word, held until the next completion
wordDone  output  1  one-cycle pulse, cycle after a word completes
bitCount  output  counterWidth  bits shifted in the current word, 0..width-1

Behaviour:
- Reset, sampled on a rising clk, takes effect that edge. It clears mem, wordOut, bitCount and wordDone to 0, so serialDataOut=0. It overrides all other inputs. Reset mid-word discards the partial word, and no wordDone is issued.
- Priority per edge: reset > parallelLoad > peripheralClkEdge.
- parallelLoad=1: mem <= parallelDataIn; bitCount <= 0; wordDone <= 0. A coincident strobe is dropped, with no shift and no count.
- Strobe only, lsbFirst=0: mem <= {mem[width-2:0], serialDataIn}.
- Strobe only, lsbFirst=1: mem <= {serialDataIn, mem[width-1:1]}.
- Strobe with bitCount < width-1: bitCount increments; wordDone <= 0.
- Strobe with bitCount == width-1:
  - bitCount wraps to 0.
  - wordOut <= the post-shift mem value, i.e. the full new word.
  - wordDone <= 1 for exactly one cycle.
- Back-to-back words need no idle cycle. Consecutive completions give wordDone pulses separated by width strobes.
- No strobe and no load: mem, bitCount and wordOut hold; wordDone <= 0.
- Strobe held high for N cycles = N shifts. The edge detection is upstream, not in this block.
- parallelDataOut and serialDataOut are combinational from mem, with no added latency. All other outputs are registered.
- Counter logic must not rely on power-of-two width: wrap is an explicit compare against width-1.
- Loading resets framing. The loaded word shifts out over the next width strobes. Completion of that word produces wordOut holding the bits shifted in during those strobes.

Test Plan:
- Reset, then 8 strobes (width=8, lsbFirst=0) with serialDataIn 1,0,1,0,0,1,0,1 -> parallelDataOut=0xA5. After the 8th strobe: wordOut=0xA5, wordDone high exactly one cycle, bitCount=0.
- parallelLoad with 0xA5, then 8 strobes with serialDataIn=0 -> serialDataOut before each strobe reads 1,0,1,0,0,1,0,1. Final parallelDataOut=0x00 and wordOut=0x00, with one wordDone pulse.
- Bit order: serialDataIn 1,1,0,0,0,0,0,0 over 8 strobes -> wordOut=0xC0 for lsbFirst=0 and 0x03 for lsbFirst=1. For lsbFirst=1, serialDataOut tracks mem[0].
- After 3 strobes (bitCount=3), assert parallelLoad=1 with 0x3C and strobe together -> mem=0x3C, bitCount=0, no wordDone. A full word then needs 8 further strobes.
- After 5 strobes, pulse reset for one cycle -> all outputs 0. The next wordDone occurs only on the 8th subsequent strobe. Reset asserted concurrently with strobe and load -> all outputs 0 and no pulse.
- width=12, counterWidth=4: 24 consecutive strobes with serialDataIn alternating starting 1 -> two wordDone pulses 12 strobes apart, wordOut=0xAAA both times, and bitCount never exceeds 11.
